// File: rtl/pair_judge.sv
// Two-player memory-game turn judge: collects two picks, holds them face-up,
// then scores a pair or hands the turn over; also enforces a per-turn time limit.
module pair_judge #(
  parameter int unsigned SHOW_CYCLES = 25000000,
  parameter int unsigned TURN_CYCLES = 250000000,
  parameter int unsigned PAIRS       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       select,
  input  logic [3:0] cursor,
  input  logic [3:0] card_label,
  input  logic       card_taken,
  output logic       player,
  output logic       par,
  output logic       hide,
  output logic [3:0] first_idx,
  output logic [3:0] second_idx,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       busy,
  output logic       stop_timer,
  output logic       finish,
  output logic [1:0] winner
);

  localparam int unsigned HW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TURN_CYCLES);
  localparam logic [HW-1:0] HoldLoad = HW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] TurnLast = TW'(TURN_CYCLES - 1);
  localparam logic [3:0]    PairsW   = 4'(PAIRS);

  typedef enum logic [1:0] {StWait1, StWait2, StHold, StDone} state_e;

  state_e        state_q, state_d;
  logic          player_q, player_d;
  logic [3:0]    first_idx_q, first_idx_d;
  logic [3:0]    second_idx_q, second_idx_d;
  logic [3:0]    first_label_q, first_label_d;
  logic          match_q, match_d;
  logic [3:0]    score0_q, score0_d;
  logic [3:0]    score1_q, score1_d;
  logic [3:0]    matched_q, matched_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic          par_q, par_d;
  logic          hide_q, hide_d;
  logic          stop_q, stop_d;

  logic pick_ok;
  logic pick2_ok;
  logic timeout;

  assign pick_ok  = select && !card_taken;
  assign pick2_ok = pick_ok && (cursor != first_idx_q);
  assign timeout  = (turn_q == TurnLast);

  // Next-state: picks, hold countdown with judgement, turn timeout.
  always_comb begin
    state_d       = state_q;
    player_d      = player_q;
    first_idx_d   = first_idx_q;
    second_idx_d  = second_idx_q;
    first_label_d = first_label_q;
    match_d       = match_q;
    score0_d      = score0_q;
    score1_d      = score1_q;
    matched_d     = matched_q;
    hold_d        = hold_q;
    turn_d        = turn_q;
    par_d         = 1'b0;
    hide_d        = 1'b0;
    stop_d        = 1'b0;
    unique case (state_q)
      StWait1: begin
        if (pick_ok) begin
          first_idx_d   = cursor;
          first_label_d = card_label;
          turn_d        = '0;
          state_d       = StWait2;
        end else if (timeout) begin
          stop_d   = 1'b1;
          player_d = ~player_q;
          turn_d   = '0;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      StWait2: begin
        // A valid pick beats a same-cycle timeout.
        if (pick2_ok) begin
          second_idx_d = cursor;
          match_d      = (card_label == first_label_q);
          hold_d       = HoldLoad;
          turn_d       = '0;
          state_d      = StHold;
        end else if (timeout) begin
          stop_d   = 1'b1;
          hide_d   = 1'b1;
          player_d = ~player_q;
          turn_d   = '0;
          state_d  = StWait1;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          turn_d = '0;
          if (match_q) begin
            par_d     = 1'b1;
            matched_d = matched_q + 4'd1;
            if (!player_q && score0_q != 4'hf) score0_d = score0_q + 4'd1;
            if (player_q && score1_q != 4'hf)  score1_d = score1_q + 4'd1;
            state_d = (matched_q + 4'd1 == PairsW) ? StDone : StWait1;
          end else begin
            hide_d   = 1'b1;
            player_d = ~player_q;
            state_d  = StWait1;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      StDone: begin
      end
      default: state_d = StWait1;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StWait1;
      player_q      <= 1'b0;
      first_idx_q   <= '0;
      second_idx_q  <= '0;
      first_label_q <= '0;
      match_q       <= 1'b0;
      score0_q      <= '0;
      score1_q      <= '0;
      matched_q     <= '0;
      hold_q        <= '0;
      turn_q        <= '0;
      par_q         <= 1'b0;
      hide_q        <= 1'b0;
      stop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      player_q      <= player_d;
      first_idx_q   <= first_idx_d;
      second_idx_q  <= second_idx_d;
      first_label_q <= first_label_d;
      match_q       <= match_d;
      score0_q      <= score0_d;
      score1_q      <= score1_d;
      matched_q     <= matched_d;
      hold_q        <= hold_d;
      turn_q        <= turn_d;
      par_q         <= par_d;
      hide_q        <= hide_d;
      stop_q        <= stop_d;
    end
  end

  // Status outputs decoded from state and scores.
  always_comb begin
    winner = 2'b00;
    if (state_q == StDone) begin
      if (score0_q > score1_q)      winner = 2'b01;
      else if (score1_q > score0_q) winner = 2'b10;
      else                          winner = 2'b11;
    end
  end

  assign player     = player_q;
  assign par        = par_q;
  assign hide       = hide_q;
  assign stop_timer = stop_q;
  assign first_idx  = first_idx_q;
  assign second_idx = second_idx_q;
  assign score0     = score0_q;
  assign score1     = score1_q;
  assign busy       = (state_q == StHold);
  assign finish     = (state_q == StDone);

endmodule

// File: tb/tb_pair_judge.sv
// Bench for pair_judge: directed game scenarios plus random play, all checked
// against a turn-level game model.
module tb_pair_judge;

  localparam int SHOW  = 4;
  localparam int TURN  = 20;
  localparam int NPAIR = 2;

  localparam int PickFirst  = 0;
  localparam int PickSecond = 1;
  localparam int Showing    = 2;
  localparam int Over       = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       select = 1'b0;
  logic [3:0] cursor = '0;
  logic [3:0] card_label = '0;
  logic       card_taken = 1'b0;
  logic       player, par, hide, busy, stop_timer, finish;
  logic [3:0] first_idx, second_idx, score0, score1;
  logic [1:0] winner;

  pair_judge #(
    .SHOW_CYCLES(SHOW),
    .TURN_CYCLES(TURN),
    .PAIRS      (NPAIR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .select    (select),
    .cursor    (cursor),
    .card_label(card_label),
    .card_taken(card_taken),
    .player    (player),
    .par       (par),
    .hide      (hide),
    .first_idx (first_idx),
    .second_idx(second_idx),
    .score0    (score0),
    .score1    (score1),
    .busy      (busy),
    .stop_timer(stop_timer),
    .finish    (finish),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Game model: phase of the turn, cards shown, idle time, scores.
  int m_ph, m_player, m_first, m_second, m_flab, m_won, m_age, m_shown;
  int m_score[2];
  bit m_same, m_par, m_hide, m_stop;
  bit taken[16];

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = PickFirst; m_player = 0; m_first = 0; m_second = 0; m_flab = 0;
    m_won = 0; m_age = 0; m_shown = 0; m_score[0] = 0; m_score[1] = 0;
    m_same = 0; m_par = 0; m_hide = 0; m_stop = 0;
  endtask

  // One clock of play given the inputs seen at that edge.
  task automatic model_step(input bit s, input int c, input int l, input bit t);
    bit ok;
    ok = s && !t;
    m_par = 0; m_hide = 0; m_stop = 0;
    case (m_ph)
      PickFirst: begin
        if (ok) begin
          m_first = c; m_flab = l; m_ph = PickSecond; m_age = 0;
        end else begin
          m_age++;
          if (m_age == TURN) begin m_stop = 1; m_player = 1 - m_player; m_age = 0; end
        end
      end
      PickSecond: begin
        if (ok && c != m_first) begin
          m_second = c; m_same = (l == m_flab); m_ph = Showing; m_shown = 0;
        end else begin
          m_age++;
          if (m_age == TURN) begin
            m_stop = 1; m_hide = 1; m_player = 1 - m_player; m_age = 0; m_ph = PickFirst;
          end
        end
      end
      Showing: begin
        m_shown++;
        if (m_shown == SHOW) begin
          m_age = 0;
          if (m_same) begin
            m_par = 1;
            if (m_score[m_player] < 15) m_score[m_player]++;
            m_won++;
            taken[m_first] = 1; taken[m_second] = 1;
            m_ph = (m_won == NPAIR) ? Over : PickFirst;
          end else begin
            m_hide = 1; m_player = 1 - m_player; m_ph = PickFirst;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    int w;
    w = 0;
    if (m_ph == Over) w = (m_score[0] > m_score[1]) ? 1 : (m_score[0] < m_score[1]) ? 2 : 3;
    check_val("player", int'(player), m_player);
    check_val("par", int'(par), int'(m_par));
    check_val("hide", int'(hide), int'(m_hide));
    check_val("stop_timer", int'(stop_timer), int'(m_stop));
    check_val("first_idx", int'(first_idx), m_first);
    check_val("second_idx", int'(second_idx), m_second);
    check_val("score0", int'(score0), m_score[0]);
    check_val("score1", int'(score1), m_score[1]);
    check_val("busy", int'(busy), int'(m_ph == Showing));
    check_val("finish", int'(finish), int'(m_ph == Over));
    check_val("winner", int'(winner), w);
  endtask

  // Check outputs on the falling edge, then drive inputs for the next rising edge.
  task automatic cyc(input bit s, input logic [3:0] c, input logic [3:0] l, input bit t);
    @(negedge clk);
    compare_all();
    select = s; cursor = c; card_label = l; card_taken = t;
    model_step(s, int'(c), int'(l), t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; select = 1'b0; cursor = '0; card_label = '0; card_taken = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) taken[i] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_step(1'b0, 0, 0, 1'b0);
  endtask

  // Two picks then the full show time; returns at the cycle the verdict pulse is visible.
  task automatic play_pair(input logic [3:0] c1, input logic [3:0] l1,
                           input logic [3:0] c2, input logic [3:0] l2);
    cyc(1'b1, c1, l1, 1'b0);
    cyc(1'b1, c2, l2, 1'b0);
    idle(SHOW + 1);
  endtask

  initial begin
    logic [3:0] c;
    bit s, t;
    int rate, after;

    model_reset();
    do_reset();
    idle(1);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_winner", int'(winner), 0);

    // Match by player 0.
    cyc(1'b1, 4'd3, 4'd5, 1'b0);
    cyc(1'b1, 4'd9, 4'd5, 1'b0);
    for (int i = 0; i < SHOW; i++) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b0);
      check_val("match_busy", int'(busy), 1);
    end
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    check_val("match_par", int'(par), 1);
    check_val("match_score0", int'(score0), 1);
    check_val("match_player", int'(player), 0);
    idle(1);
    check_val("match_par_once", int'(par), 0);

    // Miss hands the turn to player 1.
    do_reset();
    play_pair(4'd3, 4'd5, 4'd4, 4'd6);
    check_val("miss_hide", int'(hide), 1);
    check_val("miss_par", int'(par), 0);
    check_val("miss_player", int'(player), 1);
    check_val("miss_scores", int'(score0) + int'(score1), 0);

    // Ignored picks: repeat first cell, taken cell, picks while showing.
    do_reset();
    cyc(1'b1, 4'd3, 4'd5, 1'b0);
    cyc(1'b1, 4'd3, 4'd5, 1'b0);
    cyc(1'b1, 4'd7, 4'd5, 1'b1);
    cyc(1'b1, 4'd9, 4'd7, 1'b0);
    check_val("ign_first", int'(first_idx), 3);
    check_val("ign_busy_before", int'(busy), 0);
    cyc(1'b1, 4'd10, 4'd5, 1'b0);
    cyc(1'b1, 4'd11, 4'd5, 1'b0);
    check_val("ign_second", int'(second_idx), 9);
    check_val("ign_hold_busy", int'(busy), 1);
    idle(4);
    check_val("ign_first_after", int'(first_idx), 3);

    // Timeout while waiting for the second pick.
    do_reset();
    cyc(1'b1, 4'd3, 4'd5, 1'b0);
    for (int i = 0; i < TURN; i++) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b0);
      check_val("to_early_stop", int'(stop_timer), 0);
    end
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    check_val("to_stop", int'(stop_timer), 1);
    check_val("to_hide", int'(hide), 1);
    check_val("to_player", int'(player), 1);
    idle(1);
    check_val("to_stop_once", int'(stop_timer), 0);

    // A pick on the timeout cycle wins.
    do_reset();
    cyc(1'b1, 4'd3, 4'd5, 1'b0);
    idle(TURN - 1);
    cyc(1'b1, 4'd6, 4'd5, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    check_val("to_pick_stop", int'(stop_timer), 0);
    check_val("to_pick_busy", int'(busy), 1);

    // Player 0 takes both pairs; later selects ignored.
    do_reset();
    play_pair(4'd3, 4'd5, 4'd9, 4'd5);
    play_pair(4'd1, 4'd2, 4'd2, 4'd2);
    check_val("fin_finish", int'(finish), 1);
    check_val("fin_winner", int'(winner), 1);
    cyc(1'b1, 4'd5, 4'd5, 1'b0);
    cyc(1'b1, 4'd6, 4'd5, 1'b0);
    idle(SHOW + 2);
    check_val("fin_first_kept", int'(first_idx), 1);
    check_val("fin_still", int'(finish), 1);

    // One pair each ends in a tie.
    do_reset();
    play_pair(4'd3, 4'd5, 4'd9, 4'd5);
    play_pair(4'd1, 4'd2, 4'd4, 4'd6);
    play_pair(4'd1, 4'd2, 4'd2, 4'd2);
    check_val("tie_winner", int'(winner), 3);
    check_val("tie_score1", int'(score1), 1);

    // Reset during the show aborts the verdict.
    do_reset();
    cyc(1'b1, 4'd3, 4'd5, 1'b0);
    cyc(1'b1, 4'd9, 4'd5, 1'b0);
    idle(2);
    #2 rst = 1'b0;
    #1;
    check_val("mid_busy", int'(busy), 0);
    check_val("mid_first", int'(first_idx), 0);
    check_val("mid_second", int'(second_idx), 0);
    check_val("mid_par", int'(par), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_step(1'b0, 0, 0, 1'b0);
    idle(SHOW + 3);
    check_val("mid_score0", int'(score0), 0);

    // Random games.
    for (int g = 0; g < 10; g++) begin
      do_reset();
      rate  = $urandom_range(1, 3);
      after = 0;
      for (int i = 0; i < 500 && after < 12; i++) begin
        s = (rate == 1) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 1);
        c = 4'($urandom_range(0, 15));
        t = taken[c] || ($urandom_range(0, 15) == 0);
        cyc(s, c, {2'b00, c[1:0]}, t);
        if (m_ph == Over) after++;
      end
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
